uart_rx_core: RTL and testbench



---
 rtl/uart_rx_core.sv | 269 ++++++++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampling UART receiver (8 data bits, LSB first, 1 stop bit) with holding register and sticky flags.
// Define UART_RX_PARITY_EN to insert an even-parity bit before the stop bit and add the parity_err output.

module uart_rx_core #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  input  logic       receive,
  input  logic       rx_interrupt_en,
  output logic [7:0] rx_data,
  output logic       rx_interrupt_status,
  output logic       rx_irq,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       rx_busy
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TICK_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SAMP_W  = $clog2(OVERSAMPLE);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [SAMP_W-1:0] SAMP_7    = SAMP_W'(7);
  localparam logic [SAMP_W-1:0] SAMP_8    = SAMP_W'(8);
  localparam logic [SAMP_W-1:0] SAMP_9    = SAMP_W'(9);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t              state_q, state_d;
  logic                rxd_meta_q, rxd_meta_d;
  logic                rxd_sync_q, rxd_sync_d;
  logic                rxd_prev_q, rxd_prev_d;
  logic [1:0]          flush_q, flush_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [SAMP_W-1:0]   sample_cnt_q, sample_cnt_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic                captured_q, captured_d;
  logic                s7_q, s7_d;
  logic                s8_q, s8_d;
  logic [7:0]          shift_q, shift_d;
  logic                accept_q, accept_d;
  logic                ferr_set_q, ferr_set_d;
  logic [7:0]          rx_data_q, rx_data_d;
  logic                status_q, status_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;
  logic                busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic                par_bad_q, par_bad_d;
  logic                perr_set_q, perr_set_d;
  logic                parity_err_q, parity_err_d;
`endif

  logic tick, at_s7, at_s8, at_s9, at_last, majority;

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block leaves a signal unassigned (no latch).
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    sample_cnt_d = sample_cnt_q;
    bit_idx_d    = bit_idx_q;
    captured_d   = captured_q;
    s7_d         = s7_q;
    s8_d         = s8_q;
    shift_d      = shift_q;
    accept_d     = 1'b0;
    ferr_set_d   = 1'b0;
    rx_data_d    = rx_data_q;
    status_d     = status_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    perr_set_d   = 1'b0;
    parity_err_d = parity_err_q;
`endif

    // The edge detector only trusts rxd_prev once both synchronizer stages hold real line samples,
    // so a line that is already low when reset is released never looks like a start edge.
    rxd_meta_d = uart_rxd;
    rxd_sync_d = rxd_meta_q;
    flush_d    = {flush_q[0], 1'b1};
    rxd_prev_d = flush_q[1] ? rxd_sync_q : 1'b0;

    tick     = (state_q != S_IDLE) && (tick_cnt_q == TICK_LAST);
    at_s7    = tick && (sample_cnt_q == SAMP_7);
    at_s8    = tick && (sample_cnt_q == SAMP_8);
    at_s9    = tick && (sample_cnt_q == SAMP_9);
    at_last  = tick && (sample_cnt_q == SAMP_LAST);
    majority = (s7_q & s8_q) | (s7_q & rxd_sync_q) | (s8_q & rxd_sync_q);

    if (state_q == S_IDLE) begin
      tick_cnt_d   = '0;
      sample_cnt_d = '0;
    end else begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
      if (tick) sample_cnt_d = at_last ? '0 : sample_cnt_q + SAMP_W'(1);
    end
    if (at_s7) s7_d = rxd_sync_q;
    if (at_s8) s8_d = rxd_sync_q;

    case (state_q)
      S_IDLE: begin
        if (rxd_prev_q && !rxd_sync_q) state_d = S_START;
      end
      S_START: begin
        if (at_s9) begin
          if (!majority) begin
            state_d    = S_DATA;
            bit_idx_d  = 3'd0;
            captured_d = 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_d  = 1'b0;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (at_s9) begin
          shift_d[bit_idx_q] = majority;
          captured_d         = 1'b1;
        end
        // The tail of the start bit also passes sample 15; only advance once this bit was captured.
        if (at_last && captured_q) begin
          captured_d = 1'b0;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (at_s9) par_bad_d = majority ^ (^shift_q);
        if (at_last) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // Leave half a bit early so the next start edge is not missed.
        if (at_s9) begin
          state_d = S_IDLE;
          if (majority) begin
`ifdef UART_RX_PARITY_EN
            accept_d = !par_bad_q;
`else
            accept_d = 1'b1;
`endif
          end else begin
            ferr_set_d = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          perr_set_d = par_bad_q;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);

    if (receive) begin
      status_d    = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_d = 1'b0;
`endif
    end
    if (accept_q) begin
      rx_data_d = shift_q;
      status_d  = 1'b1;
      if (status_q && !receive) overrun_d = 1'b1;
    end
    if (ferr_set_q) frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
    if (perr_set_q) parity_err_d = 1'b1;
`endif
  end

  // NOTE: state uses non-blocking assignments only; every flop here is plain logic, so all get an async reset value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rxd_meta_q   <= 1'b1;
      rxd_sync_q   <= 1'b1;
      rxd_prev_q   <= 1'b0;
      flush_q      <= 2'b00;
      tick_cnt_q   <= '0;
      sample_cnt_q <= '0;
      bit_idx_q    <= 3'd0;
      captured_q   <= 1'b0;
      s7_q         <= 1'b1;
      s8_q         <= 1'b1;
      shift_q      <= 8'h00;
      accept_q     <= 1'b0;
      ferr_set_q   <= 1'b0;
      rx_data_q    <= 8'h00;
      status_q     <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      perr_set_q   <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rxd_meta_q   <= rxd_meta_d;
      rxd_sync_q   <= rxd_sync_d;
      rxd_prev_q   <= rxd_prev_d;
      flush_q      <= flush_d;
      tick_cnt_q   <= tick_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      bit_idx_q    <= bit_idx_d;
      captured_q   <= captured_d;
      s7_q         <= s7_d;
      s8_q         <= s8_d;
      shift_q      <= shift_d;
      accept_q     <= accept_d;
      ferr_set_q   <= ferr_set_d;
      rx_data_q    <= rx_data_d;
      status_q     <= status_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      perr_set_q   <= perr_set_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data             = rx_data_q;
  assign rx_interrupt_status = status_q;
  assign rx_irq              = status_q & rx_interrupt_en;
  assign frame_err           = frame_err_q;
  assign overrun             = overrun_q;
  assign rx_busy             = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err          = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed scenarios plus randomized frames against a register-level model.
// Runs at 64 clocks per bit (DIV=4, OVERSAMPLE=16); define UART_RX_PARITY_EN to exercise the parity build.

module tb_uart_rx_core;

  localparam int CLK_FREQ   = 6400000;
  localparam int BAUD       = 100000;
  localparam int OVERSAMPLE = 16;
  localparam int BIT_CLKS   = 64;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Acceptance becomes visible 2 sync cycles + 1 edge-detect cycle + 10 ticks (to sample 9) + 1 acceptance
  // cycle after the stop bit begins; counted in negedges from the start-bit falling edge.
  localparam int ACCEPT_EDGE = 4 + 4 * 10 + BIT_CLKS * (FRAME_BITS - 1);
  localparam int LAT_BOUND   = BIT_CLKS * FRAME_BITS;

  logic       clk = 1'b0;
  logic       reset, uart_rxd, receive, rx_interrupt_en;
  logic [7:0] rx_data;
  logic       rx_interrupt_status, rx_irq, frame_err, overrun, rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_data;
  logic       m_status, m_ferr, m_ovr;

  uart_rx_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE)) dut (
    .clk                 (clk),
    .reset               (reset),
    .uart_rxd            (uart_rxd),
    .receive             (receive),
    .rx_interrupt_en     (rx_interrupt_en),
    .rx_data             (rx_data),
    .rx_interrupt_status (rx_interrupt_status),
    .rx_irq              (rx_irq),
    .frame_err           (frame_err),
    .overrun             (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err          (parity_err),
`endif
    .rx_busy             (rx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame starting at the current negedge; returns BIT_CLKS*FRAME_BITS negedges later, line idle.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    wait_neg(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      wait_neg(BIT_CLKS);
    end
`ifdef UART_RX_PARITY_EN
    uart_rxd = (^b) ^ par_flip;
    wait_neg(BIT_CLKS);
`endif
    uart_rxd = stop_bit;
    wait_neg(BIT_CLKS);
    uart_rxd = 1'b1;
  endtask

  task automatic pulse_receive();
    receive = 1'b1;
    wait_neg(1);
    receive = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; uart_rxd = 1'b1; receive = 1'b0; rx_interrupt_en = 1'b0;
    wait_neg(4);
    reset = 1'b0;
    wait_neg(4);
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    checks++; if (rx_interrupt_status !== 1'b0) begin failures++; $display("FAIL reset_status got=%b exp=0", rx_interrupt_status); end
    checks++; if (rx_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", rx_irq); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
  endtask

  task automatic test_basic_frame();
    int cyc;
    cyc = 0;
    rx_interrupt_en = 1'b1;
    fork
      send_frame(8'h55, 1'b1);
      begin
        while (!rx_interrupt_status && cyc < LAT_BOUND) begin
          @(negedge clk);
          cyc++;
        end
      end
    join
    checks++;
    if (rx_interrupt_status !== 1'b1 || cyc > LAT_BOUND || cyc < BIT_CLKS * (FRAME_BITS - 1)) begin
      failures++; $display("FAIL basic_latency got=%0d cycles exp=%0d..%0d", cyc, BIT_CLKS * (FRAME_BITS - 1), LAT_BOUND);
    end
    checks++; if (rx_data !== 8'h55) begin failures++; $display("FAIL basic_data got=%h exp=55", rx_data); end
    checks++; if (rx_irq !== 1'b1) begin failures++; $display("FAIL basic_irq got=%b exp=1", rx_irq); end
    pulse_receive();
    checks++; if (rx_interrupt_status !== 1'b0) begin failures++; $display("FAIL basic_status_clr got=%b exp=0", rx_interrupt_status); end
    checks++; if (rx_data !== 8'h55) begin failures++; $display("FAIL basic_data_hold got=%h exp=55", rx_data); end
    checks++; if (rx_irq !== 1'b0) begin failures++; $display("FAIL basic_irq_clr got=%b exp=0", rx_irq); end
  endtask

  task automatic test_glitch();
    logic saw_busy;
    saw_busy = 1'b0;
    uart_rxd = 1'b0;
    for (int c = 0; c < 120; c++) begin
      if (c == 20) uart_rxd = 1'b1;
      @(negedge clk);
      if (rx_busy) saw_busy = 1'b1;
    end
    checks++; if (saw_busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_pulse got=%b exp=1", saw_busy); end
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL glitch_idle got=%b exp=0", rx_busy); end
    checks++; if ({rx_interrupt_status, frame_err, overrun} !== 3'b000) begin
      failures++; $display("FAIL glitch_flags got=%b exp=000", {rx_interrupt_status, frame_err, overrun});
    end
  endtask

  task automatic test_frame_error();
    send_frame(8'hA3, 1'b0);
    wait_neg(20);
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_set got=%b exp=1", frame_err); end
    checks++; if (rx_interrupt_status !== 1'b0) begin failures++; $display("FAIL ferr_status got=%b exp=0", rx_interrupt_status); end
    checks++; if (rx_data !== 8'h55) begin failures++; $display("FAIL ferr_data_hold got=%h exp=55", rx_data); end
    pulse_receive();
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_clr got=%b exp=0", frame_err); end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    wait_neg(10);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL b2b_overrun got=%b exp=1", overrun); end
    checks++; if (rx_data !== 8'h34) begin failures++; $display("FAIL b2b_data got=%h exp=34", rx_data); end
    checks++; if (rx_interrupt_status !== 1'b1) begin failures++; $display("FAIL b2b_status got=%b exp=1", rx_interrupt_status); end
    pulse_receive();
    checks++; if ({rx_interrupt_status, overrun} !== 2'b00) begin
      failures++; $display("FAIL b2b_clear got=%b exp=00", {rx_interrupt_status, overrun});
    end
    // Status is set again by 0x56; the receive strobe then lands exactly in the cycle 0x78 is accepted.
    send_frame(8'h56, 1'b1);
    fork
      send_frame(8'h78, 1'b1);
      begin
        wait_neg(ACCEPT_EDGE - 1);
        pulse_receive();
      end
    join
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL same_cycle_overrun got=%b exp=0", overrun); end
    checks++; if (rx_interrupt_status !== 1'b1) begin failures++; $display("FAIL same_cycle_status got=%b exp=1", rx_interrupt_status); end
    checks++; if (rx_data !== 8'h78) begin failures++; $display("FAIL same_cycle_data got=%h exp=78", rx_data); end
    pulse_receive();
  endtask

  task automatic test_reset_mid_frame();
    fork
      send_frame(8'hFF, 1'b1);
      begin
        wait_neg(BIT_CLKS * 5 + 32);
        reset = 1'b1;
        wait_neg(3);
        reset = 1'b0;
      end
    join
    wait_neg(10);
    checks++; if ({rx_interrupt_status, rx_busy, rx_data} !== 10'h000) begin
      failures++; $display("FAIL midreset_discard got=%b/%b/%h exp=0/0/00", rx_interrupt_status, rx_busy, rx_data);
    end
    send_frame(8'h81, 1'b1);
    wait_neg(10);
    checks++; if (rx_data !== 8'h81) begin failures++; $display("FAIL midreset_data got=%h exp=81", rx_data); end
    checks++; if (rx_interrupt_status !== 1'b1) begin failures++; $display("FAIL midreset_status got=%b exp=1", rx_interrupt_status); end
    checks++; if ({frame_err, overrun} !== 2'b00) begin failures++; $display("FAIL midreset_errs got=%b exp=00", {frame_err, overrun}); end
    pulse_receive();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    wait_neg(10);
    checks++; if (parity_err !== 1'b1) begin failures++; $display("FAIL parity_err_set got=%b exp=1", parity_err); end
    checks++; if (rx_interrupt_status !== 1'b0) begin failures++; $display("FAIL parity_discard got=%b exp=0", rx_interrupt_status); end
    pulse_receive();
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL parity_err_clr got=%b exp=0", parity_err); end
    send_frame(8'h07, 1'b1);
    wait_neg(10);
    checks++; if (rx_data !== 8'h07 || rx_interrupt_status !== 1'b1) begin
      failures++; $display("FAIL parity_good got=%h/%b exp=07/1", rx_data, rx_interrupt_status);
    end
    pulse_receive();
  endtask
`endif

  task automatic test_break();
    logic saw_busy;
    saw_busy = 1'b0;
    uart_rxd = 1'b0;
    wait_neg(BIT_CLKS * FRAME_BITS + 60);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rx_busy) saw_busy = 1'b1;
    end
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL break_ferr got=%b exp=1", frame_err); end
    checks++; if (saw_busy !== 1'b0) begin failures++; $display("FAIL break_rearm got=%b exp=0", saw_busy); end
    reset = 1'b1;
    wait_neg(3);
    reset = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rx_busy) saw_busy = 1'b1;
    end
    checks++; if (saw_busy !== 1'b0) begin failures++; $display("FAIL low_after_reset got=%b exp=0", saw_busy); end
    uart_rxd = 1'b1;
    wait_neg(20);
  endtask

  task automatic test_random_frames();
    logic [7:0] b;
    logic       good;
    int         gap;
    // test_break ended with a reset, so the register file is back at its reset values.
    m_data = 8'h00; m_status = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    for (int n = 0; n < 8; n++) begin
      b               = 8'($urandom);
      good            = ($urandom_range(0, 3) != 0);
      rx_interrupt_en = 1'($urandom_range(0, 1));
      send_frame(b, good);
      if (good) begin
        if (m_status) m_ovr = 1'b1;
        m_data   = b;
        m_status = 1'b1;
      end else begin
        m_ferr = 1'b1;
      end
      gap = good ? $urandom_range(0, 30) : $urandom_range(16, 40);
      wait_neg(gap);
      checks++; if (rx_data !== m_data) begin failures++; $display("FAIL rand%0d_data got=%h exp=%h", n, rx_data, m_data); end
      checks++; if (rx_interrupt_status !== m_status) begin failures++; $display("FAIL rand%0d_status got=%b exp=%b", n, rx_interrupt_status, m_status); end
      checks++; if (frame_err !== m_ferr) begin failures++; $display("FAIL rand%0d_ferr got=%b exp=%b", n, frame_err, m_ferr); end
      checks++; if (overrun !== m_ovr) begin failures++; $display("FAIL rand%0d_ovr got=%b exp=%b", n, overrun, m_ovr); end
      checks++; if (rx_irq !== (m_status & rx_interrupt_en)) begin
        failures++; $display("FAIL rand%0d_irq got=%b exp=%b", n, rx_irq, m_status & rx_interrupt_en);
      end
      if ($urandom_range(0, 2) == 0) begin
        pulse_receive();
        m_status = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_break();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
